// File: rtl/multiply_pipe.sv
// multiply_pipe: pipelined signed multiply / multiply-accumulate
// with stb/rdy handshakes, optional rescale and saturation.
module multiply_pipe #(
  parameter int ARGW   = 16,
  parameter int RESW   = 2*ARGW,
  parameter int STAGES = 3,
  parameter int FRAC   = 0,
  parameter bit SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arg_stb,
  input  logic [2*ARGW-1:0] arg_dat,
  input  logic              arg_acc,
  input  logic              arg_clr,
  output logic              arg_rdy,
  output logic              res_stb,
  output logic [RESW-1:0]   res_dat,
  output logic              res_ovf,
  input  logic              res_rdy
);
  localparam int PW = 2*ARGW;
  localparam int SW = ((RESW > PW) ? RESW : PW) + 2;
  localparam int PD = (STAGES > 1) ? STAGES-1 : 1;

  typedef struct packed {
    logic          v;
    logic          acc;
    logic          clr;
    logic [PW-1:0] p;
  } stg_t;

  stg_t stg_q [PD];
  stg_t stg_d [PD];
  stg_t in_s;
  stg_t tl_s;

  logic adv;

  logic signed [PW-1:0] a_x;
  logic signed [PW-1:0] b_x;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shf;
  logic signed [SW-1:0] s_x;
  logic signed [SW-1:0] a_acc;
  logic signed [SW-1:0] sum;
  logic [SW-RESW:0]     hi;
  logic                 ovf;
  logic [RESW-1:0]      lim;

  logic            res_stb_q, res_stb_d;
  logic [RESW-1:0] res_dat_q, res_dat_d;
  logic            res_ovf_q, res_ovf_d;
  logic [RESW-1:0] acc_q, acc_d;

  assign adv     = ~(res_stb_q & ~res_rdy);
  assign arg_rdy = adv;
  assign res_stb = res_stb_q;
  assign res_dat = res_dat_q;
  assign res_ovf = res_ovf_q;

  assign a_x  = {{ARGW{arg_dat[ARGW-1]}}, arg_dat[ARGW-1:0]};
  assign b_x  = {{ARGW{arg_dat[PW-1]}}, arg_dat[PW-1:ARGW]};
  // 2*ARGW bits hold any ARGW x ARGW signed product exactly
  assign prod = a_x * b_x;

  always_comb begin
    in_s     = '0;
    in_s.v   = arg_stb & adv;
    in_s.acc = arg_acc;
    in_s.clr = arg_clr;
    in_s.p   = prod;
  end

  assign tl_s = (STAGES > 1) ? stg_q[PD-1] : in_s;

  assign shf   = $signed(tl_s.p) >>> FRAC;
  assign s_x   = {{(SW-PW){shf[PW-1]}}, shf};
  assign a_acc = (tl_s.acc && !tl_s.clr)
               ? {{(SW-RESW){acc_q[RESW-1]}}, acc_q}
               : '0;
  assign sum   = a_acc + s_x;

  // in range only if all bits above the result sign bit match it
  assign hi  = sum[SW-1:RESW-1];
  assign ovf = !((&hi) || !(|hi));

  always_comb begin
    lim = sum[RESW-1:0];
    if (ovf && SAT) begin
      lim = sum[SW-1] ? {1'b1, {(RESW-1){1'b0}}}
                      : {1'b0, {(RESW-1){1'b1}}};
    end
  end

  // accumulate ops chain through acc_q in the order they reach the end
  always_comb begin
    stg_d     = stg_q;
    res_stb_d = res_stb_q;
    res_dat_d = res_dat_q;
    res_ovf_d = res_ovf_q;
    acc_d     = acc_q;
    if (adv) begin
      stg_d[0] = in_s;
      for (int i = 1; i < PD; i++) begin
        stg_d[i] = stg_q[i-1];
      end
      res_stb_d = tl_s.v;
      if (tl_s.v) begin
        res_dat_d = lim;
        res_ovf_d = ovf;
        if (tl_s.acc) begin
          acc_d = lim;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PD; i++) begin
        stg_q[i] <= '0;
      end
      res_stb_q <= 1'b0;
      res_dat_q <= '0;
      res_ovf_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      stg_q     <= stg_d;
      res_stb_q <= res_stb_d;
      res_dat_q <= res_dat_d;
      res_ovf_q <= res_ovf_d;
      acc_q     <= acc_d;
    end
  end

endmodule

// File: tb/tb_multiply_pipe.sv
// tb_multiply_pipe: scoreboard bench for multiply_pipe
// (saturating, wrapping and FRAC=15 instances share one stimulus).
module tb_multiply_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        arg_stb;
  logic [31:0] arg_dat;
  logic        arg_acc;
  logic        arg_clr;
  logic        res_rdy;
  logic        rdy [3];
  logic        stb [3];
  logic        ovf [3];
  logic [31:0] dat [3];

  always #5 clk = ~clk;

  multiply_pipe #(.ARGW(16), .RESW(32), .STAGES(3), .FRAC(0), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat(arg_dat),
    .arg_acc(arg_acc), .arg_clr(arg_clr), .arg_rdy(rdy[0]),
    .res_stb(stb[0]), .res_dat(dat[0]), .res_ovf(ovf[0]), .res_rdy(res_rdy));

  multiply_pipe #(.ARGW(16), .RESW(32), .STAGES(3), .FRAC(0), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat(arg_dat),
    .arg_acc(arg_acc), .arg_clr(arg_clr), .arg_rdy(rdy[1]),
    .res_stb(stb[1]), .res_dat(dat[1]), .res_ovf(ovf[1]), .res_rdy(res_rdy));

  multiply_pipe #(.ARGW(16), .RESW(32), .STAGES(3), .FRAC(15), .SAT(1'b1)) u_frac (
    .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat(arg_dat),
    .arg_acc(arg_acc), .arg_clr(arg_clr), .arg_rdy(rdy[2]),
    .res_stb(stb[2]), .res_dat(dat[2]), .res_ovf(ovf[2]), .res_rdy(res_rdy));

  typedef struct packed {
    logic [2:0]       o;
    logic [2:0][31:0] d;
  } exp_t;

  localparam longint MX = 2147483647;
  localparam longint MN = -MX - 1;

  exp_t   sb [$];
  exp_t   ex;
  longint macc [3];
  int     checks;
  int     errors;
  bit     accepted;
  bit     took;
  bit     sb_empty;

  function automatic void model(input int di, input int frac, input bit sat,
                                input longint a, input longint b,
                                input bit ac, input bit cl,
                                output logic [31:0] r, output logic o);
    longint s;
    s = (a * b) >>> frac;
    if (ac) s = (cl ? 64'sd0 : macc[di]) + s;
    o = (s > MX) || (s < MN);
    r = s[31:0];
    if (o && sat) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    if (ac) macc[di] = longint'($signed(r));
  endfunction

  task automatic cycle(input bit r, input bit s, input int a, input int b,
                       input bit ac, input bit cl, input bit rr);
    exp_t e;
    logic [31:0] rv;
    logic ov;
    @(negedge clk);
    rst     = r;
    arg_stb = s;
    arg_dat = {b[15:0], a[15:0]};
    arg_acc = ac;
    arg_clr = cl;
    res_rdy = rr;
    #1;
    accepted = !r && s && rdy[0];
    took     = !r && stb[0] && rr;
    if (took) begin
      if (sb.size() == 0) begin
        ex = '0;
        sb_empty = 1'b1;
      end else begin
        ex = sb.pop_front();
        sb_empty = 1'b0;
      end
    end
    if (accepted) begin
      e = '0;
      model(0, 0, 1'b1, a, b, ac, cl, rv, ov); e.d[0] = rv; e.o[0] = ov;
      model(1, 0, 1'b0, a, b, ac, cl, rv, ov); e.d[1] = rv; e.o[1] = ov;
      model(2, 15, 1'b1, a, b, ac, cl, rv, ov); e.d[2] = rv; e.o[2] = ov;
      sb.push_back(e);
    end
    if (r) begin
      sb.delete();
      macc = '{0, 0, 0};
    end
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({stb[d], ovf[d], dat[d]} !== 34'b0) begin
        errors++;
        $display("FAIL reset_out[%0d]: got stb=%b ovf=%b dat=%h, want 0 0 0",
                 d, stb[d], ovf[d], dat[d]);
      end
      checks++;
      if (rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_rdy[%0d]: got %b, want 1", d, rdy[d]);
      end
    end
  endtask

  task automatic test_latency();
    int lat = -1;
    cycle(0, 1, 3, -4, 0, 0, 1);
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL lat_accept: got arg_rdy=%b, want 1", rdy[0]);
    end
    for (int k = 1; k <= 8; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 1);
      if (took && lat < 0) begin
        lat = k;
        checks++;
        if (sb_empty || dat[0] !== 32'hFFFF_FFF4 || ovf[0] !== 1'b0 ||
            dat[0] !== ex.d[0] || dat[2] !== ex.d[2]) begin
          errors++;
          $display("FAIL lat_value: got %0d ovf=%b frac=%h, want -12 ovf=0 frac=%h",
                   $signed(dat[0]), ovf[0], dat[2], ex.d[2]);
        end
      end
      if (k == 4) begin
        checks++;
        if (stb[0] !== 1'b0) begin
          errors++;
          $display("FAIL lat_drop: got res_stb=%b, want 0", stb[0]);
        end
      end
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL lat_cycles: got %0d, want 3", lat);
    end
  endtask

  task automatic test_streaming();
    int n = 0;
    int m = 0;
    int first = -1;
    int last = -1;
    bit offer;
    for (int c = 0; c < 16; c++) begin
      offer = n < 8;
      cycle(0, offer, n, n + 1, 0, 0, 1);
      if (offer) begin
        checks++;
        if (!accepted) begin
          errors++;
          $display("FAIL stream_rdy[%0d]: got arg_rdy=%b, want 1", n, rdy[0]);
        end
        if (accepted) n++;
      end
      if (took) begin
        if (first < 0) first = c;
        last = c;
        checks++;
        if (sb_empty || dat[0] !== 32'(m * (m + 1)) || dat[0] !== ex.d[0] ||
            ovf[0] !== 1'b0) begin
          errors++;
          $display("FAIL stream_val[%0d]: got %0d, want %0d", m,
                   $signed(dat[0]), m * (m + 1));
        end
        m++;
      end
    end
    checks++;
    if (m != 8 || last - first != 7) begin
      errors++;
      $display("FAIL stream_count: got %0d results over %0d cycles, want 8 over 8",
               m, last - first + 1);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int m = 0;
    bit rr;
    bit stall_prev = 0;
    logic [31:0] prev = '0;
    for (int c = 0; c < 30; c++) begin
      rr = !(c >= 4 && c < 9);
      cycle(0, n < 6, -(n * 37 + 1), n * 11 + 5, 0, 0, rr);
      if (stb[0] && !rr) begin
        checks++;
        if (rdy[0] !== 1'b0) begin
          errors++;
          $display("FAIL bp_rdy[%0d]: got arg_rdy=%b, want 0", c, rdy[0]);
        end
      end
      if (stall_prev) begin
        checks++;
        if (dat[0] !== prev) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got %h, want %h", c, dat[0], prev);
        end
      end
      stall_prev = stb[0] && !rr;
      prev = dat[0];
      if (accepted) n++;
      if (took) begin
        checks++;
        if (sb_empty || dat[0] !== ex.d[0] ||
            dat[0] !== 32'((-(m * 37 + 1)) * (m * 11 + 5))) begin
          errors++;
          $display("FAIL bp_val[%0d]: got %0d, want %0d", m, $signed(dat[0]),
                   (-(m * 37 + 1)) * (m * 11 + 5));
        end
        m++;
      end
    end
    checks++;
    if (m != 6 || n != 6 || sb.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d in %0d out %0d left, want 6 6 0",
               n, m, sb.size());
    end
  endtask

  task automatic test_accumulate();
    int oa [5] = '{2, 4, -1, 7, 1};
    int ob [5] = '{3, 5, 1, 7, 1};
    bit oc [5] = '{1, 1, 1, 0, 1};
    bit ol [5] = '{1, 0, 0, 0, 0};
    int want [5] = '{6, 26, 25, 49, 26};
    int n = 0;
    int m = 0;
    int j;
    for (int c = 0; c < 15; c++) begin
      j = (n < 5) ? n : 0;
      cycle(0, n < 5, oa[j], ob[j], oc[j], ol[j], 1);
      if (accepted) n++;
      if (took) begin
        checks++;
        if (sb_empty || m > 4 || dat[0] !== 32'(want[m < 5 ? m : 0]) ||
            dat[0] !== ex.d[0] || dat[1] !== ex.d[1]) begin
          errors++;
          $display("FAIL acc_val[%0d]: got %0d wrap=%0d, want %0d", m,
                   $signed(dat[0]), $signed(dat[1]), want[m < 5 ? m : 0]);
        end
        m++;
      end
    end
    checks++;
    if (m != 5) begin
      errors++;
      $display("FAIL acc_count: got %0d, want 5", m);
    end
  endtask

  task automatic test_range();
    int oa [7] = '{16384, 16384, 16384, 16384, 16384, 16384, -1};
    int ob [7] = '{32767, 32767, 32767, 32767, 32767, 16384, 1};
    bit oc [7] = '{1, 1, 1, 1, 1, 0, 0};
    bit ol [7] = '{1, 0, 0, 0, 0, 0, 0};
    int n = 0;
    int m = 0;
    int j;
    for (int c = 0; c < 20; c++) begin
      j = (n < 7) ? n : 0;
      cycle(0, n < 7, oa[j], ob[j], oc[j], ol[j], 1);
      if (accepted) n++;
      if (took) begin
        for (int d = 0; d < 3; d++) begin
          checks++;
          if (sb_empty || dat[d] !== ex.d[d] || ovf[d] !== ex.o[d]) begin
            errors++;
            $display("FAIL rng_model[%0d.%0d]: got %h ovf=%b, want %h ovf=%b",
                     m, d, dat[d], ovf[d], ex.d[d], ex.o[d]);
          end
        end
        if (m == 3) begin
          checks++;
          if (dat[0] !== 32'h7FFF_0000 || ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL rng_edge: got %h ovf=%b, want 7fff0000 ovf=0",
                     dat[0], ovf[0]);
          end
        end
        if (m == 4) begin
          checks++;
          if (dat[0] !== 32'h7FFF_FFFF || ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL rng_sat: got %h ovf=%b, want 7fffffff ovf=1",
                     dat[0], ovf[0]);
          end
          checks++;
          if (dat[1] !== 32'h9FFE_C000 || ovf[1] !== 1'b1) begin
            errors++;
            $display("FAIL rng_wrap: got %h ovf=%b, want 9ffec000 ovf=1",
                     dat[1], ovf[1]);
          end
        end
        if (m == 5) begin
          checks++;
          if (dat[2] !== 32'h0000_2000 || dat[0] !== 32'h1000_0000) begin
            errors++;
            $display("FAIL rng_frac_pos: got %h full=%h, want 00002000 10000000",
                     dat[2], dat[0]);
          end
        end
        if (m == 6) begin
          checks++;
          if (dat[2] !== 32'hFFFF_FFFF || ovf[2] !== 1'b0) begin
            errors++;
            $display("FAIL rng_frac_neg: got %h ovf=%b, want ffffffff ovf=0",
                     dat[2], ovf[2]);
          end
        end
        m++;
      end
    end
    checks++;
    if (m != 7) begin
      errors++;
      $display("FAIL rng_count: got %0d, want 7", m);
    end
  endtask

  task automatic test_mid_reset();
    int m = 0;
    cycle(0, 1, 1, 1, 1, 1, 1);
    cycle(0, 1, 2, 2, 1, 0, 1);
    cycle(1, 1, 3, 3, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (stb[0] !== 1'b0 || dat[0] !== 32'h0 || ovf[0] !== 1'b0) begin
        errors++;
        $display("FAIL rst_flush[%0d]: got stb=%b dat=%h, want 0 0", k,
                 stb[0], dat[0]);
      end
    end
    cycle(0, 1, 5, 5, 1, 0, 1);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 0, 0, 0, 0, 1);
      if (took) begin
        checks++;
        if (sb_empty || dat[0] !== 32'd25 || dat[0] !== ex.d[0]) begin
          errors++;
          $display("FAIL rst_acc: got %0d, want 25", $signed(dat[0]));
        end
        m++;
      end
    end
    checks++;
    if (m != 1) begin
      errors++;
      $display("FAIL rst_count: got %0d, want 1", m);
    end
  endtask

  initial begin
    rst = 1'b1;
    arg_stb = 1'b0;
    arg_dat = '0;
    arg_acc = 1'b0;
    arg_clr = 1'b0;
    res_rdy = 1'b1;
    checks = 0;
    errors = 0;
    macc = '{0, 0, 0};
    test_reset();
    test_latency();
    test_streaming();
    test_backpressure();
    test_accumulate();
    test_range();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
